// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension stage: mode encodings and
// the skid-buffer occupancy states.
package imm_ext_pkg;

  localparam logic [1:0] MODE_SEXT   = 2'd0;
  localparam logic [1:0] MODE_ZEXT   = 2'd1;
  localparam logic [1:0] MODE_LUI    = 2'd2;
  localparam logic [1:0] MODE_BRANCH = 2'd3;

  // Buffer occupancy: nothing held, output register only, output plus skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/imm_ext_core.sv
// Purely combinational immediate extender: maps (imm_in, mode) to a
// full-width operand.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned SHAMT = 2
) (
  input  logic [IN_W-1:0]  imm_in,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] ext_out
);

  logic [OUT_W-1:0] sext_val;
  logic [OUT_W-1:0] zext_val;

  // Build the two base extensions, then select/shift by mode.
  always_comb begin
    sext_val            = {OUT_W{imm_in[IN_W-1]}};
    sext_val[IN_W-1:0]  = imm_in;
    zext_val            = '0;
    zext_val[IN_W-1:0]  = imm_in;
    ext_out             = sext_val;
    case (mode)
      MODE_SEXT:   ext_out = sext_val;
      MODE_ZEXT:   ext_out = zext_val;
      MODE_LUI:    ext_out = zext_val << (OUT_W - IN_W);
      MODE_BRANCH: ext_out = sext_val << SHAMT;
      default:     ext_out = sext_val;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate-extension stage with a two-entry skid buffer,
// valid/ready handshake on both sides and a synchronous flush.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned SHAMT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  imm_in,
  input  logic [1:0]       mode,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] data_out
);

  if (OUT_W < IN_W + SHAMT) begin : g_width_check
    $error("imm_ext_pipe: OUT_W must be >= IN_W + SHAMT");
  end

  state_e           state_q, state_d;
  logic [OUT_W-1:0] o_q, o_d;
  logic [OUT_W-1:0] s_q, s_d;
  logic             out_valid_q, in_ready_q;
  logic [OUT_W-1:0] ext_val;
  logic             in_xfer, out_xfer;

  // Extension happens on the input side so only results are buffered.
  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHAMT (SHAMT)
  ) u_core (
    .imm_in  (imm_in),
    .mode    (mode),
    .ext_out (ext_val)
  );

  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = out_valid_q && out_ready;

  // Next-state and buffer contents; flush overrides everything.
  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    s_d     = s_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d = ONE;
            o_d     = ext_val;
          end
        end
        ONE: begin
          if (in_xfer && !out_xfer) begin
            state_d = TWO;
            s_d     = ext_val;
          end else if (!in_xfer && out_xfer) begin
            state_d = EMPTY;
          end else if (in_xfer && out_xfer) begin
            o_d = ext_val;
          end
        end
        TWO: begin
          if (out_xfer) begin
            state_d = ONE;
            o_d     = s_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State, data and flag registers; flags are registered so outputs come
  // straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      o_q         <= '0;
      s_q         <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      o_q         <= o_d;
      s_q         <= s_d;
      out_valid_q <= (state_d != EMPTY);
      in_ready_q  <= (state_d != TWO);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_out  = o_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [15:0] imm_in;
  logic [1:0]  mode;
  logic [31:0] data_out;

  logic        in_valid12, in_ready12, out_valid12, out_ready12;
  logic [11:0] imm_in12;
  logic [1:0]  mode12;
  logic [31:0] data_out12;

  int unsigned total  = 0;
  int unsigned passed = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  imm_ext_pipe u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imm_in    (imm_in),
    .mode      (mode),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
  );

  imm_ext_pipe #(
    .IN_W  (12),
    .OUT_W (32),
    .SHAMT (1)
  ) u_dut12 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid12),
    .in_ready  (in_ready12),
    .imm_in    (imm_in12),
    .mode      (mode12),
    .flush     (1'b0),
    .out_valid (out_valid12),
    .out_ready (out_ready12),
    .data_out  (data_out12)
  );

  // Arithmetic reference: signed value of the immediate, scaled by a power of two.
  function automatic logic [31:0] ref_ext(int unsigned imm, logic [1:0] m, int in_w, int sh);
    longint v;
    v = longint'(imm);
    if ((m == 2'd0 || m == 2'd3) && imm >= (32'd1 << (in_w - 1))) v = v - (longint'(1) << in_w);
    if (m == 2'd2) v = v * (longint'(1) << (32 - in_w));
    if (m == 2'd3) v = v * (longint'(1) << sh);
    return v[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock: advance the model with pre-edge inputs, then compare after the edge.
  task automatic tick(input string tag);
    logic        in_x, out_x;
    logic [31:0] nv;
    in_x  = in_valid && (q.size() < 2);
    out_x = out_ready && (q.size() > 0);
    nv    = ref_ext(32'(imm_in), mode, 16, 2);
    @(posedge clk);
    #1;
    if (flush) q.delete();
    else begin
      if (out_x) void'(q.pop_front());
      if (in_x) q.push_back(nv);
    end
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() < 2));
    if (q.size() > 0) chk({tag, ".data"}, data_out, q[0]);
  endtask

  task automatic send(input logic [15:0] imm, input logic [1:0] m);
    in_valid = 1'b1;
    imm_in   = imm;
    mode     = m;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; imm_in = '0; mode = '0; flush = 1'b0; out_ready = 1'b1;
    in_valid12 = 1'b0; imm_in12 = '0; mode12 = '0; out_ready12 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.data", data_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Modes, one cycle after acceptance.
    send(16'h0001, 2'd0); tick("sext1"); chk("sext1.val", data_out, 32'h00000001);
    send(16'h8000, 2'd0); tick("sext8"); chk("sext8.val", data_out, 32'hFFFF8000);
    send(16'h8000, 2'd1); tick("zext8"); chk("zext8.val", data_out, 32'h00008000);
    send(16'h1234, 2'd2); tick("lui");   chk("lui.val",   data_out, 32'h12340000);
    send(16'hFFFF, 2'd3); tick("br");    chk("br.val",    data_out, 32'hFFFFFFFC);
    in_valid = 1'b0; tick("drain");

    // Back-pressure: A, B, C with consumer stalled.
    out_ready = 1'b0;
    send(16'h0003, 2'd0); tick("bp.a");
    send(16'h0004, 2'd0); tick("bp.b");
    chk("bp.full", 32'(in_ready), 32'd0);
    send(16'h0005, 2'd0); tick("bp.c_held");
    chk("bp.hold_data", data_out, 32'd3);
    out_ready = 1'b1;
    tick("bp.pop3"); chk("bp.val4", data_out, 32'd4);
    tick("bp.pop4"); chk("bp.val5", data_out, 32'd5);
    in_valid = 1'b0;
    tick("bp.pop5"); chk("bp.empty", 32'(out_valid), 32'd0);

    // Simultaneous in/out transfer in ONE.
    send(16'h0011, 2'd1); tick("sim.x");
    send(16'h0022, 2'd1); tick("sim.both");
    chk("sim.val", data_out, 32'h00000022);
    chk("sim.one", 32'(in_ready), 32'd1);
    in_valid = 1'b0; tick("sim.drain");

    // Flush from TWO with an incoming entry.
    out_ready = 1'b0;
    send(16'h0101, 2'd0); tick("fl.a");
    send(16'h0202, 2'd0); tick("fl.b");
    send(16'h0303, 2'd0); flush = 1'b1; tick("fl.flush");
    chk("fl.out_valid", 32'(out_valid), 32'd0);
    chk("fl.in_ready", 32'(in_ready), 32'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick("fl.after1"); tick("fl.after2");

    // Async reset mid-cycle with two entries held.
    out_ready = 1'b0;
    send(16'h0aaa, 2'd0); tick("ar.a");
    send(16'h0bbb, 2'd0); tick("ar.b");
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar.out_valid", 32'(out_valid), 32'd0);
    chk("ar.data", data_out, 32'd0);
    chk("ar.in_ready", 32'(in_ready), 32'd1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick("ar.after");

    // Parameter sweep instance.
    in_valid12 = 1'b1; imm_in12 = 12'h800; mode12 = 2'd3;
    @(posedge clk);
    #1;
    in_valid12 = 1'b0;
    chk("p12.valid", 32'(out_valid12), 32'd1);
    chk("p12.val", data_out12, 32'hFFFFF000);
    chk("p12.ref", data_out12, ref_ext(32'h800, 2'd3, 12, 1));

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      imm_in    = 16'($urandom);
      mode      = 2'($urandom);
      tick("rnd");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
